// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared definitions for the sequential ALU.
//   op_t        - op_code encoding (add/sub/and/or keep their legacy values)
//   state_t     - controller states IDLE, MUL, DIV, DONE
//   iter_mode_t - selects multiply or divide in the iterative datapath
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_MUL = 3'd6,
        OP_DIV = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_t;

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: shared shift/accumulate datapath for multiply and divide.
// One multiplier bit (shift-add) or one quotient bit (restoring division)
// is processed per cycle while run is high.
// Optional macro SEQ_ALU_DIV_EN adds the divide mode; without it only
// multiply exists and the mode port is absent.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          load operands, clear accumulator and counter
//   run            perform one iteration this cycle
//   mode           MODE_MUL / MODE_DIV (only with SEQ_ALU_DIV_EN)
//   op_a, op_b     multiplicand/dividend, multiplier/divisor
//   res_next       product or quotient after the current iteration
//   done_iter      current iteration is the last one
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int unsigned word_len = 32,
    parameter int unsigned cnt_w    = $clog2(word_len) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                run,
`ifdef SEQ_ALU_DIV_EN
    input  iter_mode_t          mode,
`endif
    input  logic [word_len-1:0] op_a,
    input  logic [word_len-1:0] op_b,
    output logic [word_len-1:0] res_next,
    output logic                done_iter
);

    // acc: product accumulator (mul) or partial remainder (div)
    // sh_a: shifted multiplicand (mul) or dividend/quotient shift register (div)
    // sh_b: shifted multiplier (mul) or divisor (div)
    logic [word_len-1:0] acc, sh_a, sh_b;
    logic [word_len-1:0] acc_step, a_step, b_step;
    logic [cnt_w-1:0]    cnt;

`ifdef SEQ_ALU_DIV_EN
    iter_mode_t          mode_q;
    logic [word_len:0]   shifted, diff;
`endif

    assign done_iter = (cnt == cnt_w'(word_len - 1));

    always_comb begin
        acc_step = acc + (sh_b[0] ? sh_a : '0);
        a_step   = sh_a << 1;
        b_step   = sh_b >> 1;
        res_next = acc_step;
`ifdef SEQ_ALU_DIV_EN
        // Quotient bits enter at the LSB of sh_a as dividend bits leave the MSB.
        shifted = {acc, sh_a[word_len-1]};
        diff    = shifted - {1'b0, sh_b};
        if (mode_q == MODE_DIV) begin
            b_step = sh_b;
            if (!diff[word_len]) begin
                acc_step = diff[word_len-1:0];
                a_step   = {sh_a[word_len-2:0], 1'b1};
            end else begin
                acc_step = shifted[word_len-1:0];
                a_step   = {sh_a[word_len-2:0], 1'b0};
            end
            res_next = a_step;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            sh_a   <= '0;
            sh_b   <= '0;
            cnt    <= '0;
`ifdef SEQ_ALU_DIV_EN
            mode_q <= MODE_MUL;
`endif
        end else if (start) begin
            acc    <= '0;
            sh_a   <= op_a;
            sh_b   <= op_b;
            cnt    <= '0;
`ifdef SEQ_ALU_DIV_EN
            mode_q <= mode;
`endif
        end else if (run) begin
            acc    <= acc_step;
            sh_a   <= a_step;
            sh_b   <= b_step;
            cnt    <= cnt + cnt_w'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU behind a start/busy/done handshake.
// Ops 0-5 finish in one cycle; mul and div iterate word_len cycles in
// seq_alu_iter. Result and flags are registered and held until next done.
// Optional macro SEQ_ALU_DIV_EN enables divide; otherwise op 7 returns 0
// in one cycle and div_zero stays 0.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          request, accepted in IDLE or DONE
//   op_code        0 add 1 sub 2 and 3 or 4 xor 5 slt 6 mul 7 div
//   in1, in2       operands, sampled on accept
//   result         registered result
//   zer_flag       result == 0
//   neg_flag       result MSB
//   busy           high in MUL/DIV
//   done           one-cycle pulse when result is valid
//   div_zero       divide by zero on the last accepted op
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned word_len = 32,
    parameter int unsigned cnt_w    = $clog2(word_len) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          op_code,
    input  logic [word_len-1:0] in1,
    input  logic [word_len-1:0] in2,
    output logic [word_len-1:0] result,
    output logic                zer_flag,
    output logic                neg_flag,
    output logic                busy,
    output logic                done,
    output logic                div_zero
);

    state_t              state, next_state;
    logic                accept, load_res, done_iter, slt;
    logic [word_len-1:0] res_val, iter_res;
`ifdef SEQ_ALU_DIV_EN
    logic                dz_set;
    iter_mode_t          iter_mode;
`endif

    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign busy   = (state == ST_MUL) || (state == ST_DIV);
    assign done   = (state == ST_DONE);
    assign slt    = $signed(in1) < $signed(in2);

    always_comb begin
        next_state = state;
        load_res   = 1'b0;
        res_val    = '0;
`ifdef SEQ_ALU_DIV_EN
        dz_set     = 1'b0;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                if (state == ST_DONE) next_state = ST_IDLE;
                if (accept) begin
                    next_state = ST_DONE;
                    load_res   = 1'b1;
                    case (op_t'(op_code))
                        OP_ADD: res_val = in1 + in2;
                        OP_SUB: res_val = in1 - in2;
                        OP_AND: res_val = in1 & in2;
                        OP_OR:  res_val = in1 | in2;
                        OP_XOR: res_val = in1 ^ in2;
                        OP_SLT: res_val = {{(word_len-1){1'b0}}, slt};
                        OP_MUL: begin
                            next_state = ST_MUL;
                            load_res   = 1'b0;
                        end
                        OP_DIV: begin
`ifdef SEQ_ALU_DIV_EN
                            if (in2 == '0) begin
                                res_val = '1;
                                dz_set  = 1'b1;
                            end else begin
                                next_state = ST_DIV;
                                load_res   = 1'b0;
                            end
`else
                            res_val = '0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (done_iter) begin
                    next_state = ST_DONE;
                    load_res   = 1'b1;
                    res_val    = iter_res;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            result   <= '0;
            zer_flag <= 1'b0;
            neg_flag <= 1'b0;
        end else begin
            state <= next_state;
            if (load_res) begin
                result   <= res_val;
                zer_flag <= (res_val == '0);
                neg_flag <= res_val[word_len-1];
            end
        end
    end

`ifdef SEQ_ALU_DIV_EN
    assign iter_mode = (op_t'(op_code) == OP_DIV) ? MODE_DIV : MODE_MUL;

    always_ff @(posedge clk) begin
        if (rst)         div_zero <= 1'b0;
        else if (accept) div_zero <= dz_set;
    end
`else
    assign div_zero = 1'b0;
`endif

    seq_alu_iter #(
        .word_len (word_len),
        .cnt_w    (cnt_w)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (accept),
        .run       (busy),
`ifdef SEQ_ALU_DIV_EN
        .mode      (iter_mode),
`endif
        .op_a      (in1),
        .op_b      (in2),
        .res_next  (iter_res),
        .done_iter (done_iter)
    );

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu, 32-bit and 8-bit instances.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s = 1'b0;
    logic [2:0]  op_s = '0;
    logic [31:0] a_s = '0, b_s = '0;
    bit          sel = 1'b0;   // 0: 32-bit DUT, 1: 8-bit DUT
    int          errors = 0, checks = 0;

    logic [31:0] res32;
    logic [7:0]  res8;
    logic        zer32, neg32, busy32, done32, dz32;
    logic        zer8, neg8, busy8, done8, dz8;
    logic [31:0] obs_res;
    logic        obs_zer, obs_neg, obs_busy, obs_done, obs_dz;

    always #5 clk = ~clk;

    seq_alu #(.word_len(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start_s && !sel), .op_code(op_s),
        .in1(a_s), .in2(b_s), .result(res32), .zer_flag(zer32),
        .neg_flag(neg32), .busy(busy32), .done(done32), .div_zero(dz32)
    );

    seq_alu #(.word_len(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_s && sel), .op_code(op_s),
        .in1(a_s[7:0]), .in2(b_s[7:0]), .result(res8), .zer_flag(zer8),
        .neg_flag(neg8), .busy(busy8), .done(done8), .div_zero(dz8)
    );

    assign obs_res  = sel ? {24'b0, res8} : res32;
    assign obs_zer  = sel ? zer8  : zer32;
    assign obs_neg  = sel ? neg8  : neg32;
    assign obs_busy = sel ? busy8 : busy32;
    assign obs_done = sel ? done8 : done32;
    assign obs_dz   = sel ? dz8   : dz32;

    // Reference: plain arithmetic on width-w values.
    function automatic void model(input int unsigned w, input logic [2:0] op,
                                  input logic [31:0] a_in, input logic [31:0] b_in,
                                  output logic [31:0] r, output bit dz, output int lat);
        longint unsigned mask, a, b, r64;
        longint sa, sb;
        mask = (64'd1 << w) - 64'd1;
        a = 64'(a_in) & mask;
        b = 64'(b_in) & mask;
        sa = (a > (mask >> 1)) ? longint'(a) - longint'(mask + 1) : longint'(a);
        sb = (b > (mask >> 1)) ? longint'(b) - longint'(mask + 1) : longint'(b);
        dz = 1'b0;
        lat = 1;
        r64 = 0;
        case (op)
            3'd0: r64 = a + b;
            3'd1: r64 = a - b;
            3'd2: r64 = a & b;
            3'd3: r64 = a | b;
            3'd4: r64 = a ^ b;
            3'd5: r64 = (sa < sb) ? 1 : 0;
            3'd6: begin r64 = a * b; lat = int'(w) + 1; end
            default: begin
`ifdef SEQ_ALU_DIV_EN
                if (b == 0) begin r64 = mask; dz = 1'b1; end
                else begin r64 = a / b; lat = int'(w) + 1; end
`else
                r64 = 0;
`endif
            end
        endcase
        r = 32'(r64 & mask);
    endfunction

    // Issue one request at the current negedge and wait (bounded) for done.
    // Inputs are scrambled after acceptance; poke pulses start mid-operation.
    task automatic do_op(input bit s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit poke,
                         output int lat, output bit busy_ok);
        sel = s; op_s = op; a_s = a; b_s = b; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        op_s = 3'($urandom); a_s = $urandom; b_s = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        while (!obs_done && lat < 100) begin
            if (!obs_busy) busy_ok = 1'b0;
            start_s = poke && (lat == 3);
            @(negedge clk);
            lat++;
        end
        start_s = 1'b0;
    endtask

    task automatic test_reset();
        int lat, pulses;
        bit bok;
        checks++; if (obs_res !== 32'h0 || obs_zer !== 1'b0 || obs_neg !== 1'b0 ||
                      obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_dz !== 1'b0) begin
            errors++; $display("FAIL reset_init: res=%h z=%b n=%b busy=%b done=%b dz=%b expected all 0",
                               obs_res, obs_zer, obs_neg, obs_busy, obs_done, obs_dz);
        end
        do_op(0, 3'd1, 32'd5, 32'd7, 0, lat, bok);
        @(negedge clk);
        sel = 0; op_s = 3'd6; a_s = 32'h1234; b_s = 32'h5678; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (obs_done) pulses++;
        end
        rst = 1'b0;
        checks++; if (obs_res !== 32'h0 || obs_zer !== 1'b0 || obs_neg !== 1'b0 ||
                      obs_busy !== 1'b0 || obs_dz !== 1'b0) begin
            errors++; $display("FAIL reset_mid_mul: res=%h z=%b n=%b busy=%b dz=%b expected all 0",
                               obs_res, obs_zer, obs_neg, obs_busy, obs_dz);
        end
        repeat (40) begin
            @(negedge clk);
            if (obs_done) pulses++;
        end
        checks++; if (pulses != 0) begin
            errors++; $display("FAIL reset_no_done: done pulses=%0d expected 0", pulses);
        end
    endtask

    task automatic test_sub();
        int lat;
        bit bok;
        do_op(0, 3'd1, 32'd5, 32'd7, 0, lat, bok);
        checks++; if (lat != 1) begin
            errors++; $display("FAIL sub_latency: got %0d expected 1", lat);
        end
        checks++; if (obs_res !== 32'hFFFF_FFFE || obs_neg !== 1'b1 || obs_zer !== 1'b0) begin
            errors++; $display("FAIL sub_result: res=%h n=%b z=%b expected fffffffe 1 0",
                               obs_res, obs_neg, obs_zer);
        end
        @(negedge clk);
        checks++; if (obs_done !== 1'b0 || obs_res !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL sub_hold: done=%b res=%h expected 0 fffffffe", obs_done, obs_res);
        end
    endtask

    task automatic test_mul();
        int lat, pulses;
        bit bok;
        do_op(0, 3'd6, 32'h0001_0003, 32'h0000_0010, 1, lat, bok);
        checks++; if (lat != 33 || !bok) begin
            errors++; $display("FAIL mul_latency: lat=%0d busy_ok=%b expected 33 1", lat, bok);
        end
        checks++; if (obs_res !== 32'h0010_0030 || obs_zer !== 1'b0 || obs_neg !== 1'b0 || obs_busy !== 1'b0) begin
            errors++; $display("FAIL mul_result: res=%h z=%b n=%b busy=%b expected 00100030 0 0 0",
                               obs_res, obs_zer, obs_neg, obs_busy);
        end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (obs_done) pulses++;
        end
        checks++; if (pulses != 0 || obs_res !== 32'h0010_0030) begin
            errors++; $display("FAIL mul_poke_ignored: pulses=%0d res=%h expected 0 00100030", pulses, obs_res);
        end
    endtask

    task automatic test_div();
        int lat;
        bit bok;
`ifdef SEQ_ALU_DIV_EN
        int          exp_lat  = 33;
        logic [31:0] exp_q    = 32'd14;
        int          exp_lat0 = 1;
        logic [31:0] exp_r0   = 32'hFFFF_FFFF;
        bit          exp_dz0  = 1'b1;
`else
        int          exp_lat  = 1;
        logic [31:0] exp_q    = 32'd0;
        int          exp_lat0 = 1;
        logic [31:0] exp_r0   = 32'd0;
        bit          exp_dz0  = 1'b0;
`endif
        do_op(0, 3'd7, 32'd100, 32'd7, 0, lat, bok);
        checks++; if (lat != exp_lat || obs_res !== exp_q || obs_dz !== 1'b0 || obs_zer !== (exp_q == 0)) begin
            errors++; $display("FAIL div_result: lat=%0d res=%h dz=%b z=%b expected %0d %h 0 %b",
                               lat, obs_res, obs_dz, obs_zer, exp_lat, exp_q, exp_q == 0);
        end
        @(negedge clk);
        do_op(0, 3'd7, 32'd100, 32'd0, 0, lat, bok);
        checks++; if (lat != exp_lat0 || obs_res !== exp_r0 || obs_dz !== exp_dz0) begin
            errors++; $display("FAIL div_zero: lat=%0d res=%h dz=%b expected %0d %h %b",
                               lat, obs_res, obs_dz, exp_lat0, exp_r0, exp_dz0);
        end
        @(negedge clk);
        do_op(0, 3'd0, 32'd1, 32'd2, 0, lat, bok);
        checks++; if (obs_dz !== 1'b0 || obs_res !== 32'd3) begin
            errors++; $display("FAIL div_zero_clear: dz=%b res=%h expected 0 3", obs_dz, obs_res);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        bit bok;
        do_op(0, 3'd5, 32'hFFFF_FFFD, 32'd2, 0, lat1, bok);
        checks++; if (lat1 != 1 || obs_res !== 32'd1 || obs_zer !== 1'b0) begin
            errors++; $display("FAIL b2b_first: lat=%0d res=%h z=%b expected 1 1 0", lat1, obs_res, obs_zer);
        end
        do_op(0, 3'd0, 32'd0, 32'd0, 0, lat2, bok);
        checks++; if (lat2 != 1 || obs_res !== 32'd0 || obs_zer !== 1'b1) begin
            errors++; $display("FAIL b2b_second: lat=%0d res=%h z=%b expected 1 0 1", lat2, obs_res, obs_zer);
        end
        @(negedge clk);
        checks++; if (obs_done !== 1'b0) begin
            errors++; $display("FAIL b2b_end: done=%b expected 0", obs_done);
        end
    endtask

    task automatic test_w8();
        int lat;
        bit bok;
        do_op(1, 3'd6, 32'h0F, 32'h11, 0, lat, bok);
        checks++; if (lat != 9 || !bok || obs_res !== 32'hFF || obs_neg !== 1'b1) begin
            errors++; $display("FAIL w8_mul: lat=%0d busy_ok=%b res=%h n=%b expected 9 1 ff 1",
                               lat, bok, obs_res, obs_neg);
        end
        @(negedge clk);
        sel = 0;
    endtask

    task automatic test_random();
        logic [31:0] a, b, er, held;
        logic [2:0]  op;
        bit          edz, bok, s;
        int          elat, lat, w;
        for (int i = 0; i < 60; i++) begin
            s  = (i % 3 == 0);
            w  = s ? 8 : 32;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            model(w, op, a, b, er, edz, elat);
            do_op(s, op, a, b, 1'($urandom_range(0, 1)), lat, bok);
            checks++; if (lat != elat || !bok || obs_busy !== 1'b0) begin
                errors++; $display("FAIL rnd_timing[%0d] op=%0d w=%0d: lat=%0d busy_ok=%b busy=%b expected %0d 1 0",
                                   i, op, w, lat, bok, obs_busy, elat);
            end
            checks++; if (obs_res !== er || obs_zer !== (er == 0) || obs_neg !== er[w-1] || obs_dz !== edz) begin
                errors++; $display("FAIL rnd_result[%0d] op=%0d w=%0d a=%h b=%h: res=%h z=%b n=%b dz=%b expected %h %b %b %b",
                                   i, op, w, a, b, obs_res, obs_zer, obs_neg, obs_dz, er, er == 0, er[w-1], edz);
            end
            held = obs_res;
            @(negedge clk);
            checks++; if (obs_done !== 1'b0 || obs_res !== held) begin
                errors++; $display("FAIL rnd_hold[%0d]: done=%b res=%h expected 0 %h", i, obs_done, obs_res, held);
            end
        end
        sel = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_sub();
        test_mul();
        test_div();
        test_back_to_back();
        test_w8();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the datapath's combinational ALU.
- Keeps the existing 2-bit add/sub/and/or encoding in op_code[1:0] and adds xor, signed set-less-than, iterative multiply and iterative unsigned divide.
- Operates behind a start/busy/done handshake with registered result and flags.
- Sits in the multi-cycle datapath; the controller holds its state until done.

Parameters:
- word_len, 32, operand/result width (>= 4).
- cnt_w, $clog2(word_len)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; operands sampled when accepted
- op_code  input  3  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 mul, 7 div
- in1  input  word_len  operand A (dividend / multiplicand)
- in2  input  word_len  operand B (divisor / multiplier)
- result  output  word_len  registered result, held until next done
- zer_flag  output  1  result == 0, registered with result
- neg_flag  output  1  result[word_len-1], registered with result
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  single-cycle pulse when result is valid
- div_zero  output  1  set with done when op 7 and in2 == 0; cleared on next accept

Behaviour:
- Reset: state IDLE; result, zer_flag, neg_flag, busy, done, div_zero, counter and internal registers all 0.
- A request is accepted when start=1 and state is IDLE or DONE. start is ignored while busy; no queuing.
- Operands and op_code are latched on acceptance. Later input changes have no effect.
- States:
  - IDLE: on accept, op 0-5 -> DONE; op 6 -> MUL; op 7 with in2 != 0 -> DIV; op 7 with in2 == 0 -> DONE.
  - MUL: shift-add of latched operands, one multiplier bit per cycle for word_len cycles, then -> DONE.
  - DIV: restoring division, one quotient bit per cycle for word_len cycles, then -> DONE.
  - DONE: done=1 for exactly this cycle. An accept here is legal (back-to-back) and follows the IDLE rules; otherwise -> IDLE.
- Latency from the accept edge to the done pulse: 1 cycle for ops 0-5 and div-by-zero; word_len+1 cycles for mul and div.
- busy=1 in MUL/DIV only.
- Arithmetic:
  - add/sub: modulo 2^word_len.
  - slt: signed compare; result 1 or 0.
  - mul: low word_len bits of the unsigned product (equals the signed low word).
  - div: unsigned quotient; remainder is discarded.
  - div by zero: result all ones, div_zero=1.
- Flags and result update only on the cycle done is asserted.
- rst mid-operation aborts the operation: no done pulse, all outputs return to reset values.

Optional Feature:
- Macro SEQ_ALU_DIV_EN.
- Defined: DIV state, divider datapath and div_zero behave as specified.
- Undefined:
  - Divider logic is absent and div_zero is tied to 0.
  - Op 7 completes in 1 cycle with result 0 and zer_flag=1.

Decomposition:
- Shared package/header holds:
  - op_code constants (existing add/sub/and/or values preserved, plus xor/slt/mul/div);
  - FSM state encodings: IDLE, MUL, DIV, DONE.
- One sub-module, seq_alu_iter, implements the shared shift/accumulate datapath for mul and div: start, mode, counter, done_iter.
- The top level contains the FSM, single-cycle ops, handshake and flags.

Test Plan:
- Reset: hold rst 2 cycles during a MUL -> no done pulse; result=0, busy=0, flags=0.
- op 1, in1=5, in2=7, start 1 cycle -> done next cycle; result=0xFFFFFFFE, neg_flag=1, zer_flag=0.
- op 6, in1=0x0001_0003, in2=0x0000_0010 -> busy 32 cycles, done at cycle 33; result=0x0010_0030. start pulsed mid-op is ignored.
- op 7, in1=100, in2=7 -> result=14 at cycle 33. op 7, in2=0 -> done at cycle 1, result=0xFFFFFFFF, div_zero=1.
- Back-to-back: accept op 5 (in1=-3, in2=2) then start again in the DONE cycle with op 0 (in1=in2=0) -> result 1, then result 0 with zer_flag=1; two consecutive done pulses.
- word_len=8 build: op 6 with 0x0F × 0x11 -> result 0xFF at cycle 9.
